// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command decoder:
//   - FSM state encoding (IDLE, PEND, DECODE, RESP)
//   - default command / terminator / response character constants
//   - fold_upper(): maps 'a'..'z' onto 'A'..'Z', every other byte unchanged
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [7:0] DEF_CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] DEF_CMD_CLR  = 8'h43;  // 'C'
  localparam logic [7:0] DEF_CMD_MODE = 8'h4D;  // 'M'
  localparam logic [7:0] DEF_TERM     = 8'h0D;  // CR
  localparam logic [7:0] DEF_ACK_CHAR = 8'h4B;  // 'K'
  localparam logic [7:0] DEF_NAK_CHAR = 8'h3F;  // '?'
  localparam logic [7:0] CHR_LF       = 8'h0A;

  // Lowercase letters differ from uppercase only in bit 5.
  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b & 8'hDF;
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
// Pops bytes from a first-word-fall-through RX FIFO, recognises single-char
// commands terminated by CR, drives the run/mode levels and the clear pulse,
// and optionally pushes an ACK/NAK byte into the TX FIFO.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   rx_valid     RX FIFO not empty
//   rx_data      RX FIFO head byte
//   rx_rd        pop strobe (combinational, head consumed this cycle)
//   tx_full      TX FIFO full
//   tx_wr        push strobe into TX FIFO
//   tx_wdata     response byte, holds last pushed value while tx_wr=0
//   uart_enable  run level (toggled by CMD_RUN)
//   uart_mode    mode level (toggled by CMD_MODE)
//   uart_clear   one-cycle pulse (CMD_CLR)
//   err_cnt      illegal-byte counter, saturates at 8'hFF
// ---------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] CMD_RUN  = DEF_CMD_RUN,
  parameter logic [7:0] CMD_CLR  = DEF_CMD_CLR,
  parameter logic [7:0] CMD_MODE = DEF_CMD_MODE,
  parameter logic [7:0] TERM     = DEF_TERM,
  parameter logic [7:0] ACK_CHAR = DEF_ACK_CHAR,
  parameter logic [7:0] NAK_CHAR = DEF_NAK_CHAR,
  parameter logic       RESP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_wdata,
  output logic       uart_enable,
  output logic       uart_mode,
  output logic       uart_clear,
  output logic [7:0] err_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [1:0] state;
  logic       pend_vld;
  logic [7:0] pend_cmd;
  logic [7:0] byte_reg;
  logic [7:0] byte_fold;
  logic [7:0] resp_byte;
  logic [7:0] tx_wdata_q;
  logic       is_cmd;

  assign byte_fold = fold_upper(byte_reg);
  assign is_cmd    = (byte_fold == CMD_RUN) || (byte_fold == CMD_CLR) ||
                     (byte_fold == CMD_MODE);

  // Pops only from the two waiting states; DECODE and RESP never pop, which
  // gives the FIFO empty flag a cycle to settle between consecutive pops.
  assign rx_rd    = ((state == ST_IDLE) || (state == ST_PEND)) && rx_valid;
  assign tx_wr    = RESP_EN && (state == ST_RESP) && !tx_full;
  assign tx_wdata = tx_wr ? resp_byte : tx_wdata_q;

  // Control: FSM, pending flag, output levels and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend_vld    <= 1'b0;
      uart_enable <= 1'b0;
      uart_mode   <= 1'b0;
      uart_clear  <= 1'b0;
      err_cnt     <= 8'h00;
      tx_wdata_q  <= 8'h00;
    end else begin
      uart_clear <= 1'b0;
      case (state)
        ST_IDLE, ST_PEND: begin
          if (rx_valid) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_cmd) begin
            pend_vld <= 1'b1;
            state    <= ST_PEND;
          end else if (byte_fold == TERM) begin
            if (pend_vld) begin
              pend_vld <= 1'b0;
              if (pend_cmd == CMD_RUN)  uart_enable <= ~uart_enable;
              if (pend_cmd == CMD_MODE) uart_mode   <= ~uart_mode;
              if (pend_cmd == CMD_CLR)  uart_clear  <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end else if (byte_fold == CHR_LF) begin
            state <= pend_vld ? ST_PEND : ST_IDLE;
          end else begin
            pend_vld <= 1'b0;
            err_cnt  <= sat_inc(err_cnt);
            state    <= ST_RESP;
          end
        end
        default: begin  // ST_RESP
          if (tx_wr) tx_wdata_q <= resp_byte;
          if (!RESP_EN || !tx_full) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data: captured byte, pending command, response byte (no reset needed)
  always_ff @(posedge clk) begin
    if (rx_rd) byte_reg <= rx_data;
    if (state == ST_DECODE) begin
      if (is_cmd) pend_cmd <= byte_fold;
      resp_byte <= (byte_fold == TERM) ? ACK_CHAR : NAK_CHAR;
    end
  end

endmodule
